// File: rtl/rf_top.sv
`default_nettype none
// ============================================================================
//  Module      : rf_top
//  Description : Architectural register file with two combinational read
//                ports (same-cycle write bypass) plus exception-state holder:
//                rm0/rm1 capture, USER/SUPERVISOR privilege FSM, sticky
//                double-fault flag and saturating exception counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_top #(
  parameter int NUM_REGS        = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int PC_WIDTH        = 32,
  parameter int XCPT_ADDR_WIDTH = 32,
  parameter int CNT_WIDTH       = 16,
  localparam int ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          src1_addr,
  input  logic [ADDR_W-1:0]          src2_addr,
  output logic [DATA_WIDTH-1:0]      src1_data,
  output logic [DATA_WIDTH-1:0]      src2_data,
  input  logic                       req_to_RF_writeEn,
  input  logic [ADDR_W-1:0]          req_to_RF_dest,
  input  logic [DATA_WIDTH-1:0]      req_to_RF_data,
  input  logic                       xcpt_valid,
  input  logic [PC_WIDTH-1:0]        rmPC,
  input  logic [XCPT_ADDR_WIDTH-1:0] rmAddr,
  input  logic                       iret_valid,
  output logic [PC_WIDTH-1:0]        rm0_data,
  output logic [XCPT_ADDR_WIDTH-1:0] rm1_data,
  output logic                       priv_mode,
  output logic                       xcpt_taken,
  output logic                       double_fault,
  output logic [CNT_WIDTH-1:0]       xcpt_count
);

  typedef enum logic [0:0] {
    ST_USER       = 1'b0,
    ST_SUPERVISOR = 1'b1
  } priv_e;

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];
  priv_e                      state_q, state_d;
  logic [PC_WIDTH-1:0]        rm0_q, rm0_d;
  logic [XCPT_ADDR_WIDTH-1:0] rm1_q, rm1_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       taken_q, taken_d;
  logic                       dfault_q, dfault_d;

  // A faulting instruction never commits, and r0 is never written.
  logic w_wr_live;
  logic w_commit;
  assign w_wr_live = req_to_RF_writeEn && !xcpt_valid;
  assign w_commit  = w_wr_live && (req_to_RF_dest != '0);

  // Register storage: cleared on reset, one committed write per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_commit) begin
      regs_q[req_to_RF_dest] <= req_to_RF_data;
    end
  end

  // Read ports: r0 reads zero, then the in-flight write, then storage.
  always_comb begin
    src1_data = regs_q[src1_addr];
    src2_data = regs_q[src2_addr];
    if (w_wr_live && (req_to_RF_dest == src1_addr)) src1_data = req_to_RF_data;
    if (w_wr_live && (req_to_RF_dest == src2_addr)) src2_data = req_to_RF_data;
    if (src1_addr == '0) src1_data = '0;
    if (src2_addr == '0) src2_data = '0;
  end

  // Privilege / exception-state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_USER;
      rm0_q    <= '0;
      rm1_q    <= '0;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rm0_q    <= rm0_d;
      rm1_q    <= rm1_d;
      cnt_q    <= cnt_d;
      taken_q  <= taken_d;
      dfault_q <= dfault_d;
    end
  end

  // Next-state: exception beats iret; a nested exception only flags a
  // double fault and leaves the captured state untouched.
  always_comb begin
    state_d  = state_q;
    rm0_d    = rm0_q;
    rm1_d    = rm1_q;
    cnt_d    = cnt_q;
    taken_d  = 1'b0;
    dfault_d = dfault_q;
    unique case (state_q)
      ST_USER: begin
        if (xcpt_valid) begin
          state_d = ST_SUPERVISOR;
          rm0_d   = rmPC;
          rm1_d   = rmAddr;
          taken_d = 1'b1;
          if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      ST_SUPERVISOR: begin
        if (xcpt_valid) begin
          dfault_d = 1'b1;
        end else if (iret_valid) begin
          state_d = ST_USER;
        end
      end
      default: state_d = ST_USER;
    endcase
  end

  assign rm0_data     = rm0_q;
  assign rm1_data     = rm1_q;
  assign priv_mode    = state_q;
  assign xcpt_taken   = taken_q;
  assign double_fault = dfault_q;
  assign xcpt_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_top
//  Description : Self-checking bench for rf_top: directed scenarios with
//                literal expectations, then randomized traffic compared
//                every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_top;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] src1_addr, src2_addr;
  logic [DW-1:0] src1_data, src2_data;
  logic          req_to_RF_writeEn;
  logic [AW-1:0] req_to_RF_dest;
  logic [DW-1:0] req_to_RF_data;
  logic          xcpt_valid;
  logic [31:0]   rmPC, rmAddr;
  logic          iret_valid;
  logic [31:0]   rm0_data, rm1_data;
  logic          priv_mode, xcpt_taken, double_fault;
  logic [CW-1:0] xcpt_count;

  rf_top #(.NUM_REGS(NREG), .DATA_WIDTH(DW), .PC_WIDTH(32),
           .XCPT_ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .src1_data(src1_data), .src2_data(src2_data),
    .req_to_RF_writeEn(req_to_RF_writeEn), .req_to_RF_dest(req_to_RF_dest),
    .req_to_RF_data(req_to_RF_data),
    .xcpt_valid(xcpt_valid), .rmPC(rmPC), .rmAddr(rmAddr),
    .iret_valid(iret_valid),
    .rm0_data(rm0_data), .rm1_data(rm1_data), .priv_mode(priv_mode),
    .xcpt_taken(xcpt_taken), .double_fault(double_fault),
    .xcpt_count(xcpt_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the architectural state.
  logic [DW-1:0] m_regs [NREG];
  bit            m_sup;
  logic [31:0]   m_rm0, m_rm1;
  int            m_cnt;
  bit            m_taken, m_df;

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_sup = 0; m_rm0 = '0; m_rm1 = '0; m_cnt = 0; m_taken = 0; m_df = 0;
      chk_en = 1'b1;
    end else begin
      if (req_to_RF_writeEn && !xcpt_valid && req_to_RF_dest != 0)
        m_regs[req_to_RF_dest] = req_to_RF_data;
      m_taken = 0;
      if (xcpt_valid) begin
        if (!m_sup) begin
          m_sup = 1; m_rm0 = rmPC; m_rm1 = rmAddr; m_taken = 1;
          if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else begin
          m_df = 1;
        end
      end else if (iret_valid && m_sup) begin
        m_sup = 0;
      end
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (req_to_RF_writeEn && !xcpt_valid && req_to_RF_dest == a) return req_to_RF_data;
    return m_regs[a];
  endfunction

  // Compare process: every cycle, midway between rising edges.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("src1_data", src1_data, m_read(src1_addr));
      chk("src2_data", src2_data, m_read(src2_addr));
      chk("rm0", rm0_data, m_rm0);
      chk("rm1", rm1_data, m_rm1);
      chk("priv_mode", priv_mode, m_sup);
      chk("xcpt_taken", xcpt_taken, m_taken);
      chk("double_fault", double_fault, m_df);
      chk("xcpt_count", xcpt_count, m_cnt);
    end
  end

  task automatic idle();
    reset = 0; req_to_RF_writeEn = 0; req_to_RF_dest = '0; req_to_RF_data = '0;
    xcpt_valid = 0; rmPC = '0; rmAddr = '0; iret_valid = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    src1_addr = '0; src2_addr = '0;
    reset = 1;
    tick(); tick();
    reset = 0;

    // Reset state on every index of both ports
    for (int i = 0; i < NREG; i++) begin
      src1_addr = AW'(i); src2_addr = AW'(NREG - 1 - i);
      #1;
      chk("reset_rd1", src1_data, 0);
      chk("reset_rd2", src2_data, 0);
    end
    chk("reset_priv", priv_mode, 0);
    chk("reset_cnt", xcpt_count, 0);
    chk("reset_df", double_fault, 0);
    tick();

    // Write with same-cycle bypass, then from storage
    req_to_RF_writeEn = 1; req_to_RF_dest = 5; req_to_RF_data = 32'hDEADBEEF; src1_addr = 5;
    #1 chk("bypass_r5", src1_data, 32'hDEADBEEF);
    tick(); idle();
    #1 chk("stored_r5", src1_data, 32'hDEADBEEF);
    req_to_RF_writeEn = 1; req_to_RF_dest = 0; req_to_RF_data = 32'h1234; src1_addr = 0;
    #1 chk("r0_bypass", src1_data, 0);
    tick(); idle();
    #1 chk("r0_stored", src1_data, 0);

    // Exception suppresses the write
    req_to_RF_writeEn = 1; req_to_RF_dest = 7; req_to_RF_data = 32'h55;
    xcpt_valid = 1; rmPC = 32'h1000; rmAddr = 32'h2004; src2_addr = 7;
    #1 chk("xcpt_nobypass", src2_data, 0);
    tick(); idle();
    #1;
    chk("xcpt_r7", src2_data, 0);
    chk("xcpt_rm0", rm0_data, 32'h1000);
    chk("xcpt_rm1", rm1_data, 32'h2004);
    chk("xcpt_priv", priv_mode, 1);
    chk("xcpt_taken", xcpt_taken, 1);
    chk("xcpt_cnt", xcpt_count, 1);
    tick();
    chk("taken_pulse", xcpt_taken, 0);

    // Nested exception then iret
    xcpt_valid = 1; rmPC = 32'h3000; rmAddr = 32'h9;
    tick(); idle();
    chk("nest_rm0", rm0_data, 32'h1000);
    chk("nest_df", double_fault, 1);
    chk("nest_cnt", xcpt_count, 1);
    chk("nest_taken", xcpt_taken, 0);
    iret_valid = 1;
    tick(); idle();
    chk("iret_priv", priv_mode, 0);

    // Simultaneous xcpt+iret in SUPERVISOR, then iret in USER
    xcpt_valid = 1; rmPC = 32'h4000; rmAddr = 32'h4004;
    tick(); idle();
    chk("enter2_cnt", xcpt_count, 2);
    xcpt_valid = 1; iret_valid = 1; rmPC = 32'h5000;
    tick(); idle();
    chk("both_priv", priv_mode, 1);
    chk("both_rm0", rm0_data, 32'h4000);
    iret_valid = 1;
    tick(); idle();
    iret_valid = 1;
    tick(); idle();
    chk("user_iret_priv", priv_mode, 0);
    chk("user_iret_taken", xcpt_taken, 0);

    // Saturation, then reset coincident with an exception
    for (int k = 0; k < 5; k++) begin
      xcpt_valid = 1; rmPC = 32'h100 * k;
      tick(); idle();
      iret_valid = 1;
      tick(); idle();
    end
    chk("sat_cnt", xcpt_count, 3);
    reset = 1; xcpt_valid = 1; rmPC = 32'hABCD;
    tick(); idle();
    src1_addr = 5;
    #1;
    chk("rst_rd", src1_data, 0);
    chk("rst_priv", priv_mode, 0);
    chk("rst_rm0", rm0_data, 0);
    chk("rst_rm1", rm1_data, 0);
    chk("rst_cnt", xcpt_count, 0);
    chk("rst_df", double_fault, 0);
    chk("rst_taken", xcpt_taken, 0);

    // Randomized traffic checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset             = ($urandom_range(0, 99) == 0);
      req_to_RF_writeEn = $urandom_range(0, 1);
      req_to_RF_dest    = AW'($urandom_range(0, 7));
      req_to_RF_data    = $urandom;
      xcpt_valid        = ($urandom_range(0, 7) == 0);
      iret_valid        = ($urandom_range(0, 4) == 0);
      rmPC              = $urandom;
      rmAddr            = $urandom;
      src1_addr = ($urandom_range(0, 3) == 0) ? req_to_RF_dest : AW'($urandom_range(0, 7));
      src2_addr = ($urandom_range(0, 3) == 0) ? req_to_RF_dest : AW'($urandom_range(0, NREG - 1));
    end
    tick(); idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
